// File: rtl/mul_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_seq_ctrl
// Brief    : Iterative radix-2 shift-add sequencer for RV32M MUL/MULH/MULHSU/
//            MULHU. Optional macro MUL_EARLY_OUT_EN ends CALC once the
//            remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] res
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0]       c_OP_MUL    = 2'b00;
   localparam logic [1:0]       c_OP_MULH   = 2'b01;
   localparam logic [1:0]       c_OP_MULHSU = 2'b10;
   localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(XLEN - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*XLEN-1:0]   r_acc;
   logic [2*XLEN-1:0]   r_ma;
   logic [XLEN-1:0]     r_mb;
   logic                r_neg;
   logic [1:0]          r_op;
   logic [XLEN-1:0]     r_res;

   logic                w_accept;
   logic                w_sign_a;
   logic                w_sign_b;
   logic [XLEN-1:0]     w_mag_a;
   logic [XLEN-1:0]     w_mag_b;
   logic                w_calc_last;
   logic [2*XLEN-1:0]   w_acc_fix;

   assign w_accept = start & ~flush;

   // Magnitudes stay unsigned, so |0x80000000| becomes 2^31 without overflow.
   assign w_sign_a = ((op == c_OP_MULH) || (op == c_OP_MULHSU)) & in_a[XLEN-1];
   assign w_sign_b = (op == c_OP_MULH) & in_b[XLEN-1];
   assign w_mag_a  = w_sign_a ? (~in_a + XLEN'(1)) : in_a;
   assign w_mag_b  = w_sign_b ? (~in_b + XLEN'(1)) : in_b;

`ifdef MUL_EARLY_OUT_EN
   assign w_calc_last = (r_cnt == c_CNT_LAST) || (r_mb[XLEN-1:1] == '0);
`else
   assign w_calc_last = (r_cnt == c_CNT_LAST);
`endif

   assign w_acc_fix = r_neg ? (~r_acc + (2*XLEN)'(1)) : r_acc;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept)   w_state_next = S_CALC;
         S_CALC: begin
            if (flush)            w_state_next = S_IDLE;
            else if (w_calc_last) w_state_next = S_FIX;
         end
         S_FIX:  w_state_next = flush ? S_IDLE : S_DONE;
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_cnt <= '0;
         r_acc <= '0;
         r_ma  <= '0;
         r_mb  <= '0;
         r_neg <= 1'b0;
         r_op  <= '0;
         r_res <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ma  <= {{XLEN{1'b0}}, w_mag_a};
                  r_mb  <= w_mag_b;
                  r_neg <= w_sign_a ^ w_sign_b;
                  r_op  <= op;
                  r_cnt <= '0;
                  r_acc <= '0;
               end
            end
            S_CALC: begin
               if (!flush) begin
                  if (r_mb[0]) r_acc <= r_acc + r_ma;
                  r_ma  <= r_ma << 1;
                  r_mb  <= r_mb >> 1;
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_FIX: begin
               // A flushed FIX must leave the previous result visible.
               if (!flush) begin
                  r_res <= (r_op == c_OP_MUL) ? w_acc_fix[XLEN-1:0]
                                              : w_acc_fix[2*XLEN-1:XLEN];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state == S_CALC) || (r_state == S_FIX);
   assign done = (r_state == S_DONE);
   assign res  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_ctrl
// Brief    : Directed self-checking bench for mul_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

   localparam int XLEN = 32;

   logic            CLK   = 1'b0;
   logic            RSTn  = 1'b0;
   logic            start = 1'b0;
   logic            flush = 1'b0;
   logic [1:0]      op    = 2'b00;
   logic [XLEN-1:0] in_a  = '0;
   logic [XLEN-1:0] in_b  = '0;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] res;

   int checks = 0;
   int errors = 0;

   mul_seq_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .start (start),
      .op    (op),
      .in_a  (in_a),
      .in_b  (in_b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .res   (res)
   );

   always #5 CLK = ~CLK;

   // Expected done cycle (cycle 1 = first cycle after the start edge).
   function automatic int exp_lat(input int early);
`ifdef MUL_EARLY_OUT_EN
      return early;
`else
      return XLEN + 2;
`endif
   endfunction

   // Stimulus only: issues one op and reports the done cycle (-1 on timeout).
   task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b,
                         output int done_cyc, output int busy_cyc);
      @(negedge CLK);
      op = o; in_a = a; in_b = b; start = 1'b1;
      @(negedge CLK);
      start = 1'b0; op = ~o; in_a = ~a; in_b = ~b;
      done_cyc = -1;
      busy_cyc = 0;
      for (int i = 1; i <= 200; i++) begin
         if (i > 1) @(negedge CLK);
         if (busy) busy_cyc++;
         if (done) begin
            done_cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 00000000", res); end
      RSTn = 1'b1;
   endtask

   task automatic test_mul_basic;
      int dc, bc;
      run_op(2'b00, 32'd7, 32'd6, dc, bc);
      checks++; if (res !== 32'h0000002A) begin errors++; $display("FAIL basic_res got %h want 0000002a", res); end
      checks++; if (dc !== exp_lat(5)) begin errors++; $display("FAIL basic_latency got %0d want %0d", dc, exp_lat(5)); end
      checks++; if (bc !== exp_lat(5) - 1) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, exp_lat(5) - 1); end
   endtask

   task automatic test_flush;
      int dc, bc, done_seen;
      @(negedge CLK);
      op = 2'b00; in_a = 32'd7; in_b = 32'h0010_0006; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (9) @(negedge CLK);
      flush = 1'b1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %0b want 1", busy); end
      @(negedge CLK);
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %0b want 0", busy); end
      checks++; if (res !== 32'h0000002A) begin errors++; $display("FAIL flush_res_kept got %h want 0000002a", res); end
      done_seen = 0;
      repeat (40) begin
         @(negedge CLK);
         if (done || busy) done_seen++;
      end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done got %0d active cycles want 0", done_seen); end
      run_op(2'b00, 32'd9, 32'd9, dc, bc);
      checks++; if (res !== 32'h00000051) begin errors++; $display("FAIL flush_next_res got %h want 00000051", res); end
      checks++; if (dc !== exp_lat(6)) begin errors++; $display("FAIL flush_next_latency got %0d want %0d", dc, exp_lat(6)); end
   endtask

   task automatic test_early_out;
      int dc, bc;
      run_op(2'b00, 32'd5, 32'd3, dc, bc);
      checks++; if (res !== 32'd15) begin errors++; $display("FAIL early_5x3_res got %h want 0000000f", res); end
      checks++; if (dc !== exp_lat(4)) begin errors++; $display("FAIL early_5x3_latency got %0d want %0d", dc, exp_lat(4)); end
      run_op(2'b00, 32'h1234_5678, 32'd0, dc, bc);
      checks++; if (res !== 32'd0) begin errors++; $display("FAIL early_bzero_res got %h want 00000000", res); end
      checks++; if (dc !== exp_lat(3)) begin errors++; $display("FAIL early_bzero_latency got %0d want %0d", dc, exp_lat(3)); end
   endtask

   task automatic test_signed_ops;
      logic [1:0]      v_op  [5];
      logic [XLEN-1:0] v_a   [5];
      logic [XLEN-1:0] v_b   [5];
      logic [XLEN-1:0] v_exp [5];
      int              v_lat [5];
      int dc, bc;
      v_op[0] = 2'b01; v_a[0] = 32'hFFFF_FFFF; v_b[0] = 32'hFFFF_FFFF; v_exp[0] = 32'h0000_0000; v_lat[0] = 3;
      v_op[1] = 2'b11; v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'hFFFF_FFFF; v_exp[1] = 32'hFFFF_FFFE; v_lat[1] = 34;
      v_op[2] = 2'b10; v_a[2] = 32'hFFFF_FFFF; v_b[2] = 32'hFFFF_FFFF; v_exp[2] = 32'hFFFF_FFFF; v_lat[2] = 34;
      v_op[3] = 2'b01; v_a[3] = 32'h8000_0000; v_b[3] = 32'h8000_0000; v_exp[3] = 32'h4000_0000; v_lat[3] = 34;
      v_op[4] = 2'b00; v_a[4] = 32'hFFFF_FFFD; v_b[4] = 32'd5;         v_exp[4] = 32'hFFFF_FFF1; v_lat[4] = 5;
      for (int k = 0; k < 5; k++) begin
         run_op(v_op[k], v_a[k], v_b[k], dc, bc);
         checks++; if (res !== v_exp[k]) begin errors++; $display("FAIL signed_res[%0d] got %h want %h", k, res, v_exp[k]); end
         checks++; if (dc !== exp_lat(v_lat[k])) begin errors++; $display("FAIL signed_latency[%0d] got %0d want %0d", k, dc, exp_lat(v_lat[k])); end
      end
   endtask

   task automatic test_reset_mid;
      int active;
      @(negedge CLK);
      op = 2'b11; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (5) @(negedge CLK);
      RSTn = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %0b want 0", done); end
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL rstmid_res got %h want 00000000", res); end
      @(negedge CLK);
      RSTn = 1'b1;
      active = 0;
      repeat (40) begin
         @(negedge CLK);
         if (done || busy) active++;
      end
      checks++; if (active !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles want 0", active); end
   endtask

   task automatic test_ignored_starts;
      int dones, first_done, busy_seen;
      @(negedge CLK);
      op = 2'b00; in_a = 32'd2; in_b = 32'h8000_0001; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      dones = 0;
      first_done = -1;
      for (int i = 1; i <= 80; i++) begin
         if (i > 1) @(negedge CLK);
         if (done) begin
            dones++;
            if (first_done < 0) first_done = i;
         end
         // Extra requests while busy and while in DONE must be dropped.
         start = (i == 5) || done;
         if (i == 5) begin
            in_a = 32'd100; in_b = 32'd100;
         end
      end
      start = 1'b0;
      checks++; if (dones !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", dones); end
      checks++; if (first_done !== exp_lat(34)) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", first_done, exp_lat(34)); end
      checks++; if (res !== 32'h0000_0002) begin errors++; $display("FAIL busy_start_res got %h want 00000002", res); end
      @(negedge CLK);
      start = 1'b1; flush = 1'b1; in_a = 32'd3; in_b = 32'd3;
      @(negedge CLK);
      start = 1'b0; flush = 1'b0;
      busy_seen = 0;
      repeat (40) begin
         if (busy || done) busy_seen++;
         @(negedge CLK);
      end
      checks++; if (busy_seen !== 0) begin errors++; $display("FAIL start_flush_idle got %0d active cycles want 0", busy_seen); end
      checks++; if (res !== 32'h0000_0002) begin errors++; $display("FAIL start_flush_res got %h want 00000002", res); end
   endtask

   initial begin
      test_reset;
      test_mul_basic;
      test_flush;
      test_early_out;
      test_signed_ops;
      test_reset_mid;
      test_ignored_starts;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
